// File: rtl/pattern_apply_check.sv
// pattern_apply_check
//   On-chip pattern applicator and response checker. Stores up to DEPTH
//   patterns, each made of a force value, an expected response and a compare
//   mask. A run applies the stored patterns one after another to a
//   combinational DUT. For each pattern it waits SETTLE cycles, strobes the
//   DUT response, compares the masked bits and reports and counts failures.
//
// Ports
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   ld_valid      : pattern write request
//   ld_ready      : storage can accept a pattern (IDLE and not full)
//   ld_pi         : force value to store
//   ld_xpct       : expected response to store
//   ld_mask       : compare mask to store (1 = compare, 0 = don't care)
//   clear         : discard stored patterns (IDLE only)
//   start         : begin a run (IDLE only)
//   stop_on_fail  : sampled at start; ends the run at the first failure
//   pi_out        : registered drive to the DUT inputs
//   po_in         : DUT outputs
//   busy          : run in progress
//   done          : one-cycle pulse at the end of a run
//   pass          : qualified by done; no failing pattern in the run
//   fail_count    : failing patterns in the last run (saturating)
//   err_valid     : one-cycle pulse per failing pattern
//   err_pat       : index of the failing pattern (held between pulses)
//   err_bits      : masked mismatch bits of the failing pattern (held)
//   pat_count     : number of stored patterns
module pattern_apply_check #(
  parameter int NIN    = 5,
  parameter int NOUT   = 2,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2,
  parameter int CW     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [NIN-1:0]           ld_pi,
  input  logic [NOUT-1:0]          ld_xpct,
  input  logic [NOUT-1:0]          ld_mask,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop_on_fail,
  output logic [NIN-1:0]           pi_out,
  input  logic [NOUT-1:0]          po_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CW-1:0]            fail_count,
  output logic                     err_valid,
  output logic [$clog2(DEPTH)-1:0] err_pat,
  output logic [NOUT-1:0]          err_bits,
  output logic [$clog2(DEPTH):0]   pat_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PCW = AW + 1;
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FORCE,
    S_WAIT,
    S_MEASURE,
    S_DONE
  } state_t;

  // Saturating increment of the fail counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) return v;
    else    return v + CW'(1);
  endfunction

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            stop_q, stop_d;
  logic [CW-1:0]   fail_q, fail_d;
  logic [NIN-1:0]  pi_q, pi_d;
  logic            errv_q, errv_d;
  logic [AW-1:0]   errp_q, errp_d;
  logic [NOUT-1:0] errb_q, errb_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic            wr_en;
  logic            is_last;
  logic [NOUT-1:0] mism;

  // Pattern storage; contents intentionally survive reset and clear.
  logic [NIN-1:0]  mem_pi_q   [DEPTH];
  logic [NOUT-1:0] mem_xpct_q [DEPTH];
  logic [NOUT-1:0] mem_mask_q [DEPTH];

  assign ld_ready = (state_q == S_IDLE) && (pc_q < PCW'(DEPTH));
  // clear wins over a same-cycle write.
  assign wr_en    = ld_valid && ld_ready && !clear;
  assign is_last  = ({1'b0, idx_q} == (pc_q - PCW'(1)));
  assign mism     = (po_in ^ mem_xpct_q[idx_q]) & mem_mask_q[idx_q];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pi_q[pc_q[AW-1:0]]   <= ld_pi;
      mem_xpct_q[pc_q[AW-1:0]] <= ld_xpct;
      mem_mask_q[pc_q[AW-1:0]] <= ld_mask;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    fail_d  = fail_q;
    pi_d    = pi_q;
    errv_d  = 1'b0;
    errp_d  = errp_q;
    errb_d  = errb_q;
    pc_d    = pc_q;
    done_d  = (state_q == S_DONE);
    pass_d  = (state_q == S_DONE) && (fail_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          pc_d = '0;
        end else begin
          if (wr_en) pc_d = pc_q + PCW'(1);
          if (start) begin
            // An empty run still reports, so the counter is zeroed either way.
            fail_d = '0;
            if (pc_q != '0) begin
              idx_d   = '0;
              stop_d  = stop_on_fail;
              state_d = S_FORCE;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_FORCE: begin
        pi_d    = mem_pi_q[idx_q];
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == SW'(SETTLE - 1)) state_d = S_MEASURE;
        else                          cnt_d   = cnt_q + SW'(1);
      end
      S_MEASURE: begin
        if (mism != '0) begin
          errv_d = 1'b1;
          errp_d = idx_q;
          errb_d = mism;
          fail_d = sat_inc(fail_q);
        end
        if (((mism != '0) && stop_q) || is_last) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_FORCE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      fail_q  <= '0;
      pi_q    <= '0;
      errv_q  <= 1'b0;
      errp_q  <= '0;
      errb_q  <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      fail_q  <= fail_d;
      pi_q    <= pi_d;
      errv_q  <= errv_d;
      errp_q  <= errp_d;
      errb_q  <= errb_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy       = (state_q == S_FORCE) || (state_q == S_WAIT) ||
                      (state_q == S_MEASURE);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_q;
  assign err_valid  = errv_q;
  assign err_pat    = errp_q;
  assign err_bits   = errb_q;
  assign pat_count  = pc_q;
  assign pi_out     = pi_q;

endmodule
